// File: rtl/paint_scheduler_pkg.sv
// rtl/paint_scheduler_pkg.sv - shared framebuffer constants, scheduler states and RGB pixel type
//
// Package fb_pkg: default screen resolution, coordinate width, the write
// scheduler state encoding and the 24-bit RGB pixel struct shared by the
// framebuffers and the VGA path.
package fb_pkg;

    localparam int W_RES   = 640;
    localparam int H_RES   = 480;
    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_STAMP = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/paint_scheduler_if.sv
// rtl/paint_scheduler_if.sv - shared framebuffer write port bundle
//
// Carries one pixel write per cycle from the scheduler to the red, green and
// blue framebuffers. There is no back-pressure.
//   wr_en        write strobe
//   wr_x, wr_y   pixel coordinate, valid while wr_en is high
//   wr_r/g/b     pixel data, valid while wr_en is high
// master: the scheduler drives the port. slave: a framebuffer consumes it.
interface paint_scheduler_if;
    import fb_pkg::*;

    logic               wr_en;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic [7:0]         wr_r;
    logic [7:0]         wr_g;
    logic [7:0]         wr_b;

    modport master (output wr_en, wr_x, wr_y, wr_r, wr_g, wr_b);
    modport slave  (input  wr_en, wr_x, wr_y, wr_r, wr_g, wr_b);
endinterface

// File: rtl/paint_scheduler_raster_counter.sv
// rtl/paint_scheduler_raster_counter.sv - 2-D raster walker, x inner, y outer
//
// Ports:
//   CLOCK_50  clock
//   reset     synchronous, active-low; returns the walker to (0,0)
//   clr       synchronous return to (0,0)
//   step      advance one point; (X_MAX-1,Y_MAX-1) wraps back to (0,0)
//   x, y      current point
//   last      high while the current point is the final one
module raster_counter #(
    parameter int X_MAX = 8,
    parameter int Y_MAX = 8,
    parameter int CW    = 12
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          clr,
    input  logic          step,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          last
);

    localparam logic [CW-1:0] X_END = CW'(X_MAX - 1);
    localparam logic [CW-1:0] Y_END = CW'(Y_MAX - 1);

    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_END) && (y_q == Y_END);

    always_ff @(posedge CLOCK_50) begin
        if (!reset || clr) begin
            x_q <= '0;
            y_q <= '0;
        end else if (step) begin
            if (x_q == X_END) begin
                x_q <= '0;
                y_q <= (y_q == Y_END) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/paint_scheduler.sv
// rtl/paint_scheduler.sv - arbitrates clear sweep and brush stamp onto the shared framebuffer write port
//
// Ports:
//   CLOCK_50              clock
//   reset                 synchronous, active-low
//   paint_en              level, brush stamping allowed
//   clear_req             one-cycle pulse, request a full-screen clear
//   cursor_x, cursor_y    brush top-left corner
//   color_r/g/b           brush colour
//   wr                    framebuffer write port (master side)
//   busy                  high while a clear or stamp write is being issued
//   clearing              high while a clear write is being issued
module paint_scheduler #(
    parameter int         W_RES   = fb_pkg::W_RES,
    parameter int         H_RES   = fb_pkg::H_RES,
    parameter int         SIZE    = 8,
    parameter logic [7:0] CLEAR_R = 8'd0,
    parameter logic [7:0] CLEAR_G = 8'd0,
    parameter logic [7:0] CLEAR_B = 8'd0
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      paint_en,
    input  logic                      clear_req,
    input  logic [10:0]               cursor_x,
    input  logic [10:0]               cursor_y,
    input  logic [7:0]                color_r,
    input  logic [7:0]                color_g,
    input  logic [7:0]                color_b,
    paint_scheduler_if.master         wr,
    output logic                      busy,
    output logic                      clearing
);
    import fb_pkg::*;

    localparam rgb_t CLEAR_RGB = '{r: CLEAR_R, g: CLEAR_G, b: CLEAR_B};

    state_t      state_q;
    logic        pending_q;
    logic        have_last_q;
    logic [10:0] last_x_q;
    logic [10:0] last_y_q;
    logic [10:0] lx_q;
    logic [10:0] ly_q;
    rgb_t        color_q;

    logic        wr_en_q;
    logic [10:0] wr_x_q;
    logic [10:0] wr_y_q;
    rgb_t        wr_rgb_q;
    logic        busy_q;
    logic        clearing_q;

    logic [10:0] clr_x;
    logic [10:0] clr_y;
    logic        clr_last;
    logic [11:0] stp_x;
    logic [11:0] stp_y;
    logic        stp_last;

    logic        go_clear;
    logic        go_stamp;
    logic        moved;
    logic [11:0] stamp_x;
    logic [11:0] stamp_y;
    logic        stamp_in;

    // A pending clear (requested mid-stamp) or a fresh request beats painting.
    assign go_clear = (state_q == S_IDLE) && (clear_req || pending_q);
    assign moved    = (cursor_x != last_x_q) || (cursor_y != last_y_q);
    assign go_stamp = (state_q == S_IDLE) && !go_clear && paint_en
                      && (!have_last_q || moved);

    // Stamp coordinates carry one extra bit so a brush hanging past the
    // right or bottom edge is detected instead of wrapping onto the screen.
    assign stamp_x  = {1'b0, lx_q} + stp_x;
    assign stamp_y  = {1'b0, ly_q} + stp_y;
    assign stamp_in = (stamp_x < 12'(W_RES)) && (stamp_y < 12'(H_RES));

    raster_counter #(.X_MAX(W_RES), .Y_MAX(H_RES), .CW(11)) u_clear_walk (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clr      (go_clear),
        .step     (state_q == S_CLEAR),
        .x        (clr_x),
        .y        (clr_y),
        .last     (clr_last)
    );

    raster_counter #(.X_MAX(SIZE), .Y_MAX(SIZE), .CW(12)) u_stamp_walk (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clr      (go_stamp),
        .step     (state_q == S_STAMP),
        .x        (stp_x),
        .y        (stp_y),
        .last     (stp_last)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q     <= S_CLEAR;
            pending_q   <= 1'b0;
            have_last_q <= 1'b0;
            last_x_q    <= '0;
            last_y_q    <= '0;
            lx_q        <= '0;
            ly_q        <= '0;
            color_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            wr_rgb_q    <= '0;
            busy_q      <= 1'b1;
            clearing_q  <= 1'b1;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    wr_en_q    <= 1'b1;
                    wr_x_q     <= clr_x;
                    wr_y_q     <= clr_y;
                    wr_rgb_q   <= CLEAR_RGB;
                    busy_q     <= 1'b1;
                    clearing_q <= 1'b1;
                    if (clr_last) begin
                        state_q     <= S_IDLE;
                        have_last_q <= 1'b0;
                    end
                end
                S_IDLE: begin
                    wr_en_q    <= 1'b0;
                    busy_q     <= 1'b0;
                    clearing_q <= 1'b0;
                    if (go_clear) begin
                        state_q   <= S_CLEAR;
                        pending_q <= 1'b0;
                    end else if (go_stamp) begin
                        state_q <= S_STAMP;
                        lx_q    <= cursor_x;
                        ly_q    <= cursor_y;
                        color_q <= '{r: color_r, g: color_g, b: color_b};
                    end
                end
                S_STAMP: begin
                    // Clipped pixels still take their cycle, just without the strobe.
                    wr_en_q    <= stamp_in;
                    wr_x_q     <= stamp_x[10:0];
                    wr_y_q     <= stamp_y[10:0];
                    wr_rgb_q   <= color_q;
                    busy_q     <= 1'b1;
                    clearing_q <= 1'b0;
                    if (clear_req) begin
                        pending_q <= 1'b1;
                    end
                    if (stp_last) begin
                        state_q     <= S_IDLE;
                        last_x_q    <= lx_q;
                        last_y_q    <= ly_q;
                        have_last_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_CLEAR;
                end
            endcase
        end
    end

    assign wr.wr_en  = wr_en_q;
    assign wr.wr_x   = wr_x_q;
    assign wr.wr_y   = wr_y_q;
    assign wr.wr_r   = wr_rgb_q.r;
    assign wr.wr_g   = wr_rgb_q.g;
    assign wr.wr_b   = wr_rgb_q.b;
    assign busy      = busy_q;
    assign clearing  = clearing_q;

endmodule

// File: tb/tb_paint_scheduler.sv
// tb/tb_paint_scheduler.sv - directed self-checking bench for paint_scheduler on a reduced 20x12 screen
module tb_paint_scheduler;

    localparam int         W  = 20;
    localparam int         H  = 12;
    localparam int         S  = 8;
    localparam logic [7:0] CR = 8'h11;
    localparam logic [7:0] CG = 8'h22;
    localparam logic [7:0] CB = 8'h33;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b0;
    logic        paint_en = 1'b0;
    logic        clear_req = 1'b0;
    logic [10:0] cursor_x = '0;
    logic [10:0] cursor_y = '0;
    logic [7:0]  color_r = '0;
    logic [7:0]  color_g = '0;
    logic [7:0]  color_b = '0;
    logic        busy;
    logic        clearing;

    int n_cmp = 0;
    int n_bad = 0;

    paint_scheduler_if wr_bus ();

    paint_scheduler #(
        .W_RES(W), .H_RES(H), .SIZE(S),
        .CLEAR_R(CR), .CLEAR_G(CG), .CLEAR_B(CB)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .paint_en  (paint_en),
        .clear_req (clear_req),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .color_r   (color_r),
        .color_g   (color_g),
        .color_b   (color_b),
        .wr        (wr_bus),
        .busy      (busy),
        .clearing  (clearing)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (wr_bus.wr_en !== 1'b0 || wr_bus.wr_x !== 11'd0 || wr_bus.wr_y !== 11'd0) begin
            n_bad++;
            $display("FAIL %s_wr: en=%b x=%0d y=%0d, want en=0 x=0 y=0", tag, wr_bus.wr_en, wr_bus.wr_x, wr_bus.wr_y);
        end
        n_cmp++;
        if ({wr_bus.wr_r, wr_bus.wr_g, wr_bus.wr_b} !== 24'h000000) begin
            n_bad++;
            $display("FAIL %s_data: rgb=%h%h%h, want 000000", tag, wr_bus.wr_r, wr_bus.wr_g, wr_bus.wr_b);
        end
        n_cmp++;
        if (busy !== 1'b1 || clearing !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_flags: busy=%b clearing=%b, want 1 1", tag, busy, clearing);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        paint_en = 1'b0;
        clear_req = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_reset_outputs("reset");
    endtask

    // Expects the first clear write to appear at the next rising edge.
    task automatic check_clear_sweep(input string tag);
        int bad = 0;
        int first_k = -1;
        logic [10:0] ex, ey;
        logic [10:0] fx, fy;
        logic fen;
        for (int k = 0; k < W * H; k++) begin
            @(negedge CLOCK_50);
            ex = 11'(k % W);
            ey = 11'(k / W);
            if (wr_bus.wr_en !== 1'b1 || wr_bus.wr_x !== ex || wr_bus.wr_y !== ey
                || wr_bus.wr_r !== CR || wr_bus.wr_g !== CG || wr_bus.wr_b !== CB
                || busy !== 1'b1 || clearing !== 1'b1) begin
                if (bad == 0) begin
                    first_k = k;
                    fen = wr_bus.wr_en;
                    fx = wr_bus.wr_x;
                    fy = wr_bus.wr_y;
                end
                bad++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s_sweep: %0d bad pixels, first at index %0d got en=%b x=%0d y=%0d, want 0 bad", tag, bad, first_k, fen, fx, fy);
        end
        @(negedge CLOCK_50);
        n_cmp++;
        if (wr_bus.wr_en !== 1'b0 || busy !== 1'b0 || clearing !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle_gap: en=%b busy=%b clearing=%b, want 0 0 0", tag, wr_bus.wr_en, busy, clearing);
        end
    endtask

    // Checks the SIZE*SIZE stamp cycles, then the IDLE cycle that follows.
    // With pre_idle set, first consumes the IDLE cycle that samples the trigger.
    task automatic check_stamp(input string tag, input int cx, input int cy,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input bit pre_idle, input int change_at, input int drop_at,
                               input int clear_at, output int pulses);
        int bad = 0;
        int first_k = -1;
        int model_pulses = 0;
        logic [10:0] ex, ey;
        logic exp_en;
        logic [10:0] save_x;
        pulses = 0;
        if (pre_idle) begin
            @(negedge CLOCK_50);
            n_cmp++;
            if (wr_bus.wr_en !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_trigger_idle: en=%b busy=%b, want 0 0", tag, wr_bus.wr_en, busy);
            end
        end
        save_x = cursor_x;
        for (int k = 0; k < S * S; k++) begin
            @(negedge CLOCK_50);
            ex = 11'(cx + k % S);
            ey = 11'(cy + k / S);
            exp_en = (cx + k % S < W) && (cy + k / S < H);
            if (exp_en) model_pulses++;
            if (wr_bus.wr_en === 1'b1) pulses++;
            if (wr_bus.wr_en !== exp_en || busy !== 1'b1 || clearing !== 1'b0
                || (exp_en && (wr_bus.wr_x !== ex || wr_bus.wr_y !== ey
                    || wr_bus.wr_r !== r || wr_bus.wr_g !== g || wr_bus.wr_b !== b))) begin
                if (bad == 0) first_k = k;
                bad++;
            end
            clear_req = (k == clear_at);
            if (k == drop_at) paint_en = 1'b0;
            if (k == change_at) begin
                color_r = ~color_r;
                color_b = ~color_b;
                cursor_x = save_x + 11'd9;
            end
            if (k == change_at + 1) cursor_x = save_x;
        end
        clear_req = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s_pixels: %0d bad cycles, first at %0d, want 0 bad", tag, bad, first_k);
        end
        n_cmp++;
        if (pulses != model_pulses) begin
            n_bad++;
            $display("FAIL %s_pulses: got %0d wr_en pulses, want %0d", tag, pulses, model_pulses);
        end
        @(negedge CLOCK_50);
        n_cmp++;
        if (wr_bus.wr_en !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_end_idle: en=%b busy=%b, want 0 0", tag, wr_bus.wr_en, busy);
        end
    endtask

    task automatic test_boot_clear();
        @(negedge CLOCK_50);
        reset = 1'b1;
        check_clear_sweep("boot");
    endtask

    task automatic test_stamp();
        int pulses;
        int extra = 0;
        cursor_x = 11'd3;
        cursor_y = 11'd2;
        color_r = 8'hFF; color_g = 8'h00; color_b = 8'h00;
        paint_en = 1'b1;
        check_stamp("stamp", 3, 2, 8'hFF, 8'h00, 8'h00, 1'b1, 5, -1, -1, pulses);
        n_cmp++;
        if (pulses != 64) begin
            n_bad++;
            $display("FAIL stamp_count: got %0d writes, want 64", pulses);
        end
        repeat (6) begin
            @(negedge CLOCK_50);
            if (wr_bus.wr_en !== 1'b0 || busy !== 1'b0) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL no_restamp: %0d active cycles with cursor unchanged, want 0", extra);
        end
    endtask

    task automatic test_corner_clip();
        int pulses;
        cursor_x = 11'd16;
        cursor_y = 11'd8;
        color_r = 8'h00; color_g = 8'hFF; color_b = 8'h00;
        check_stamp("corner", 16, 8, 8'h00, 8'hFF, 8'h00, 1'b1, -1, -1, -1, pulses);
        n_cmp++;
        if (pulses != 16) begin
            n_bad++;
            $display("FAIL corner_count: got %0d writes, want 16", pulses);
        end
    endtask

    task automatic test_clear_during_stamp();
        int pulses;
        cursor_x = 11'd5;
        cursor_y = 11'd5;
        color_r = 8'h00; color_g = 8'h00; color_b = 8'hFF;
        check_stamp("midclr", 5, 5, 8'h00, 8'h00, 8'hFF, 1'b1, -1, 20, 10, pulses);
        n_cmp++;
        if (pulses != 56) begin
            n_bad++;
            $display("FAIL midclr_count: got %0d writes, want 56", pulses);
        end
        check_clear_sweep("midclr_clear");
    endtask

    task automatic test_clear_and_paint_same_cycle();
        int pulses;
        cursor_x = 11'd7;
        cursor_y = 11'd7;
        color_r = 8'h80; color_g = 8'h81; color_b = 8'h82;
        paint_en = 1'b1;
        clear_req = 1'b1;
        @(negedge CLOCK_50);
        clear_req = 1'b0;
        n_cmp++;
        if (wr_bus.wr_en !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_no_stamp: en=%b busy=%b, want 0 0", wr_bus.wr_en, busy);
        end
        check_clear_sweep("simul_clear");
        check_stamp("after_clear", 7, 7, 8'h80, 8'h81, 8'h82, 1'b0, -1, -1, -1, pulses);
        n_cmp++;
        if (pulses != 40) begin
            n_bad++;
            $display("FAIL after_clear_count: got %0d writes, want 40", pulses);
        end
        paint_en = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        clear_req = 1'b1;
        @(negedge CLOCK_50);
        clear_req = 1'b0;
        repeat (101) @(negedge CLOCK_50);
        n_cmp++;
        if (wr_bus.wr_en !== 1'b1 || wr_bus.wr_x !== 11'd0 || wr_bus.wr_y !== 11'd5) begin
            n_bad++;
            $display("FAIL midclear_pos: en=%b x=%0d y=%0d, want en=1 x=0 y=5", wr_bus.wr_en, wr_bus.wr_x, wr_bus.wr_y);
        end
        reset = 1'b0;
        @(negedge CLOCK_50);
        check_reset_outputs("midreset");
        reset = 1'b1;
        check_clear_sweep("post_reset");
    endtask

    initial begin
        test_reset();
        test_boot_clear();
        test_stamp();
        test_corner_clip();
        test_clear_during_stamp();
        test_clear_and_paint_same_cycle();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/paint_scheduler.md
# paint_scheduler

Sequencer that owns the single write port shared by the red, green and blue framebuffer instances. It schedules two write sources onto that port: a full-screen clear sweep and a SIZE×SIZE brush stamp at the cursor position. It drives the coordinates, data and write enable consumed by all three buffers. It replaces ad-hoc muxing of clear and cursor coordinates with one arbitrated, clipped write stream.

## Interface
- W_RES, 640, horizontal resolution in pixels
- H_RES, 480, vertical resolution in pixels
- SIZE, 8, brush edge length in pixels (1..64)
- CLEAR_R / CLEAR_G / CLEAR_B, 0 / 0 / 0, colour written by the clear sweep
- CLOCK_50  in  1  system clock
- reset  in  1  reset, synchronous, active-low; clock CLOCK_50
- paint_en  in  1  level; brush stamping allowed
- clear_req  in  1  single-cycle pulse; request a full clear
- cursor_x, cursor_y  in  11 each  brush top-left corner
- color_r, color_g, color_b  in  8 each  brush colour
- wr_en  out  1  framebuffer write strobe
- wr_x, wr_y  out  11 each  write coordinate
- wr_r, wr_g, wr_b  out  8 each  write data
- busy  out  1  high in CLEAR or STAMP
- clearing  out  1  high in CLEAR

## Operation
- States: CLEAR, IDLE, STAMP.
- Reset (reset==0 at an edge): state=CLEAR, sweep counters=0, clear_pending=0, have_last=0, wr_en=0, wr_x/wr_y/wr_r/wr_g/wr_b=0, busy=1, clearing=1.
- CLEAR: one write per cycle in raster order, x 0..W_RES-1 inner, y 0..H_RES-1 outer. Data is CLEAR_R/G/B. After (W_RES-1,H_RES-1): go to IDLE, set have_last=0. clear_req during CLEAR is ignored.
- IDLE: clear_req or clear_pending → CLEAR (clear_pending cleared). Clear wins over paint in the same cycle.
  - Otherwise, if paint_en and (!have_last or cursor≠last stamped position): latch cursor and colour, go to STAMP.
  - Otherwise stay, wr_en=0.
- STAMP: walk dx 0..SIZE-1 inner, dy 0..SIZE-1 outer. Coordinate is (lx+dx, ly+dy), computed at 12 bits.
  - wr_en=1 only when lx+dx<W_RES and ly+dy<H_RES. Clipped pixels still consume their cycle.
  - Data is the latched colour. cursor/colour changes mid-stamp have no effect.
  - After the last pixel: last=(lx,ly), have_last=1, go to IDLE.
  - clear_req during STAMP sets clear_pending. The stamp is never aborted.
- paint_en falling mid-stamp does not abort the stamp.
- reset asserted mid-operation: immediate return to reset state. The next cycle after release starts the clear at (0,0).

## Timing
- All outputs registered. wr_x/wr_y/wr_r/wr_g/wr_b are valid in the same cycle wr_en=1.
- Reset release at edge N: first clear write (0,0) visible after edge N+1.
- Clear sweep: exactly W_RES·H_RES cycles (307200 default) with wr_en=1, then 1 IDLE cycle before any stamp.
- Stamp trigger sampled in IDLE at edge N. First stamp write is visible after edge N+1. STAMP occupies exactly SIZE² cycles (64 default).
- clear_req arriving during STAMP: CLEAR entered 2 cycles after the last stamp write (one IDLE cycle).
- Throughput: one pixel per cycle; no back-pressure from the buffers.

## Structure
- Shared package fb_pkg:
  - constants W_RES, H_RES, coordinate width 11;
  - state enum {S_CLEAR, S_IDLE, S_STAMP};
  - RGB struct (3×8 bits) reused by the buffers and the VGA path.
- Sub-module raster_counter (parameters X_MAX, Y_MAX):
  - inputs clr and step; outputs x, y and last (high on the final point);
  - instantiated twice: clear sweep (W_RES×H_RES) and stamp walk (SIZE×SIZE).
- Top-level mux selects the write source by state.

## Test plan
- Reset low 3 cycles, release → wr_en=1 for exactly 307200 consecutive cycles. Data 0,0,0; first write (0,0), last (639,479). busy falls the following cycle.
- After clear, paint_en=1, cursor (100,50), colour (255,0,0) → 64 writes covering x 100..107, y 50..57. Data 255,0,0; then idle with cursor unchanged (no restamp).
- Cursor (636,476), SIZE 8 → 64 STAMP cycles, 16 wr_en pulses only (x 636..639, y 476..479).
- clear_req pulse at stamp cycle 10 → stamp completes all 64 cycles; one IDLE cycle; then full clear sweep starts at (0,0).
- clear_req and paint trigger in the same IDLE cycle → CLEAR entered, no stamp writes.
- reset low at clear pixel 1000 → outputs at reset values next cycle; after release the sweep restarts at (0,0).
